// File: rtl/dpll_pkg.sv
// dpll_pkg: shared state encoding and arithmetic helpers for the frequency-lock controller.
package dpll_pkg;
   typedef enum logic [1:0] {IDLE, ARM, MEASURE, ADJUST} state_e;
   function automatic int cnt_w(input int div_w);
      return div_w + 2;
   endfunction
   function automatic int sat_add(input int v, input int s, input int max);
      return (v + s > max) ? max : v + s;
   endfunction
   function automatic int sat_sub(input int v, input int s);
      return (v < s) ? 0 : v - s;
   endfunction
endpackage

// File: rtl/dpll_ref_sync.sv
// dpll_ref_sync: brings the reference into the fast clock domain and pulses on its rising edge.
module dpll_ref_sync (
   input  logic clk_i,
   input  logic rst_i,
   input  logic osc_i,
   output logic ref_tick_o
);
   logic [2:0] sync_q;
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) sync_q <= '0;
      else sync_q <= {sync_q[1:0], osc_i};
   assign ref_tick_o = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/dpll_freq_ctrl.sv
// dpll_freq_ctrl: measures fast-clock cycles per reference period and steps the DCO trim
// until the count matches the div target, qualifying lock over several measurements.
module dpll_freq_ctrl
   import dpll_pkg::*;
#(
   parameter int DIV_W     = 5,
   parameter int TRIM_W    = 8,
   parameter int TRIM_INIT = 128,
   parameter int STEP      = 1,
   parameter int TOL       = 0,
   parameter int LOCK_CNT  = 4
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic              enable,
   input  logic              osc,
   input  logic [DIV_W-1:0]  div,
   input  logic              dco_mode,
   input  logic [TRIM_W-1:0] ext_trim,
   output logic [TRIM_W-1:0] trim,
   output logic              locked,
   output logic [DIV_W+1:0]  meas_cnt,
   output logic              meas_valid
);
   localparam int CNT_W    = cnt_w(DIV_W);
   localparam int TRIM_MAX = (1 << TRIM_W) - 1;
   localparam int LC_W     = $clog2(LOCK_CNT + 1);
   state_e state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, meas, meas_cnt_q, meas_cnt_d;
   logic [TRIM_W-1:0] trim_q, trim_d;
   logic [LC_W-1:0] lock_cnt_q, lock_cnt_d;
   logic locked_q, locked_d, meas_valid_q, meas_valid_d;
   logic ref_tick, lost, tick, low, high, div_ok;
   dpll_ref_sync u_sync (
      .clk_i      (wb_clk_i),
      .rst_i      (wb_rst_i),
      .osc_i      (osc),
      .ref_tick_o (ref_tick)
   );
   // a saturated counter means the reference vanished: report all-ones and restart
   assign lost   = &cnt_q & ~ref_tick;
   assign tick   = ref_tick | lost;
   assign meas   = &cnt_q ? cnt_q : cnt_q + CNT_W'(1);
   assign cnt_d  = tick ? '0 : cnt_q + CNT_W'(1);
   assign low    = int'(meas_cnt_q) + TOL < int'(div);
   assign high   = int'(meas_cnt_q) > int'(div) + TOL;
   assign div_ok = int'(div) >= 2;
   always_comb begin
      state_d      = state_q;
      trim_d       = trim_q;
      locked_d     = locked_q;
      lock_cnt_d   = lock_cnt_q;
      meas_cnt_d   = meas_cnt_q;
      meas_valid_d = 1'b0;
      case (state_q)
         IDLE:    state_d = ARM;
         ARM:     state_d = tick ? MEASURE : ARM;
         MEASURE: if (tick) begin
            meas_cnt_d   = meas;
            meas_valid_d = 1'b1;
            state_d      = ADJUST;
         end
         ADJUST: begin
            state_d = MEASURE;
            if (!div_ok || low || high) begin
               lock_cnt_d = '0;
               locked_d   = 1'b0;
            end else begin
               lock_cnt_d = (lock_cnt_q == LC_W'(LOCK_CNT)) ? lock_cnt_q : lock_cnt_q + LC_W'(1);
               locked_d   = int'(lock_cnt_d) >= LOCK_CNT;
            end
            if (div_ok && low) trim_d = TRIM_W'(sat_add(int'(trim_q), STEP, TRIM_MAX));
            if (div_ok && high) trim_d = TRIM_W'(sat_sub(int'(trim_q), STEP));
         end
         default: state_d = IDLE;
      endcase
      if (dco_mode && state_q != IDLE) begin
         trim_d     = ext_trim;
         locked_d   = 1'b0;
         lock_cnt_d = '0;
      end
      if (!enable) begin
         state_d      = IDLE;
         trim_d       = TRIM_W'(TRIM_INIT);
         locked_d     = 1'b0;
         lock_cnt_d   = '0;
         meas_cnt_d   = meas_cnt_q;
         meas_valid_d = 1'b0;
      end
   end
   always_ff @(posedge wb_clk_i or posedge wb_rst_i)
      if (wb_rst_i) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         trim_q       <= TRIM_W'(TRIM_INIT);
         locked_q     <= 1'b0;
         lock_cnt_q   <= '0;
         meas_cnt_q   <= '0;
         meas_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         trim_q       <= trim_d;
         locked_q     <= locked_d;
         lock_cnt_q   <= lock_cnt_d;
         meas_cnt_q   <= meas_cnt_d;
         meas_valid_q <= meas_valid_d;
      end
   assign trim       = trim_q;
   assign locked     = locked_q;
   assign meas_cnt   = meas_cnt_q;
   assign meas_valid = meas_valid_q;
endmodule

// File: tb/tb_dpll_freq_ctrl.sv
// tb_dpll_freq_ctrl: scoreboard bench; each reference period queues its expected measurement,
// trim and lock, and the monitor compares them when meas_valid pulses.
module tb_dpll_freq_ctrl;
   typedef struct {
      int     meas;
      int     trim;
      int     locked;
      longint t;
   } exp_t;
   logic       clk = 1'b0, rst, enable, osc, dco_mode;
   logic [4:0] div;
   logic [7:0] ext_trim, trim;
   logic       locked, meas_valid;
   logic [6:0] meas_cnt;
   int   n_checks = 0, n_fail = 0, n_meas = 0;
   int   per = 20, cur_per = 20, skip = 0, m_trim = 128, m_lc = 0, m_locked = 0;
   logic osc_run = 1'b1, mdl_en = 1'b0, pend = 1'b0;
   exp_t q[$];
   exp_t pe;
   dpll_freq_ctrl dut (
      .wb_clk_i   (clk),
      .wb_rst_i   (rst),
      .enable     (enable),
      .osc        (osc),
      .div        (div),
      .dco_mode   (dco_mode),
      .ext_trim   (ext_trim),
      .trim       (trim),
      .locked     (locked),
      .meas_cnt   (meas_cnt),
      .meas_valid (meas_valid)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask
   // behavioural loop model: one call per completed measurement
   task automatic model_push(input int m, input longint t);
      exp_t e;
      if (dco_mode) begin
         m_trim = int'(ext_trim); m_lc = 0; m_locked = 0;
      end else if (int'(div) < 2 || m != int'(div)) begin
         if (int'(div) >= 2 && m < int'(div)) m_trim = (m_trim == 255) ? 255 : m_trim + 1;
         if (int'(div) >= 2 && m > int'(div)) m_trim = (m_trim == 0) ? 0 : m_trim - 1;
         m_lc = 0; m_locked = 0;
      end else begin
         m_lc = (m_lc < 4) ? m_lc + 1 : 4;
         m_locked = (m_lc >= 4) ? 1 : 0;
      end
      e.meas = m; e.trim = m_trim; e.locked = m_locked; e.t = t;
      q.push_back(e);
   endtask
   initial begin
      osc = 1'b0;
      @(negedge clk);
      forever begin
         if (!osc_run) begin
            osc = 1'b0;
            @(negedge clk);
         end else begin
            osc = 1'b1;
            if (mdl_en) begin
               if (skip > 0) skip--;
               else model_push(cur_per, $time);
            end
            cur_per = per;
            repeat (cur_per / 2) @(negedge clk);
            osc = 1'b0;
            repeat (cur_per - cur_per / 2) @(negedge clk);
         end
      end
   end
   always @(negedge clk) begin
      if (pend) begin
         check("trim", trim, pe.trim);
         check("locked", locked, pe.locked);
         check("valid_pulse", meas_valid, 0);
         pend = 1'b0;
         n_meas++;
      end else if (meas_valid) begin
         if (q.size() == 0) check("unexpected_valid", 1, 0);
         else begin
            pe = q.pop_front();
            check("meas_cnt", meas_cnt, pe.meas);
            if (pe.t >= 0) check("latency", $time - pe.t, 30);
            pend = 1'b1;
         end
      end
   end
   task automatic wait_meas(input int n);
      int tgt = n_meas + n;
      int budget = 200 * n;
      while (n_meas < tgt && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      if (n_meas < tgt) check("wait_meas", n_meas, tgt);
   endtask
   task automatic start_loop();
      @(posedge osc);
      repeat (5) @(negedge clk);
      m_trim = 128; m_lc = 0; m_locked = 0;
      skip = 1; mdl_en = 1'b1; enable = 1'b1;
   endtask
   initial begin
      rst = 1'b1; enable = 1'b0; div = 5'd20; dco_mode = 1'b0; ext_trim = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_trim", trim, 128);
      check("rst_locked", locked, 0);
      check("rst_meas", meas_cnt, 0);
      check("rst_valid", meas_valid, 0);
      rst = 1'b0;
      start_loop();
      wait_meas(6);
      check("lock_a", locked, 1);
      dco_mode = 1'b1; ext_trim = 8'h40;
      @(negedge clk);
      check("dco_trim", trim, 'h40);
      check("dco_unlock", locked, 0);
      wait_meas(2);
      dco_mode = 1'b0;
      wait_meas(6);
      check("relock", locked, 1);
      per = 21;
      wait_meas(2);
      check("unlock21", locked, 0);
      per = 16;
      wait_meas(4);
      per = 24;
      wait_meas(4);
      per = 20; dco_mode = 1'b1; ext_trim = 8'd254;
      wait_meas(1);
      dco_mode = 1'b0; per = 16;
      wait_meas(4);
      check("sat_hi", trim, 255);
      dco_mode = 1'b1; ext_trim = 8'd1; per = 24;
      wait_meas(1);
      dco_mode = 1'b0;
      wait_meas(4);
      check("sat_lo", trim, 0);
      per = 20; div = 5'd1;
      wait_meas(3);
      check("div1_lock", locked, 0);
      div = 5'd20;
      wait_meas(6);
      check("lock_g", locked, 1);
      enable = 1'b0; mdl_en = 1'b0;
      @(negedge clk);
      check("dis_trim", trim, 128);
      check("dis_locked", locked, 0);
      check("meas_hold", meas_cnt, 20);
      start_loop();
      wait_meas(5);
      check("lock_h", locked, 1);
      osc_run = 1'b0;
      model_push(127, -1);
      wait_meas(1);
      #2 rst = 1'b1;
      #1;
      check("arst_trim", trim, 128);
      check("arst_locked", locked, 0);
      check("arst_meas", meas_cnt, 0);
      check("arst_valid", meas_valid, 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
